// File: rtl/move_collector.sv
// move_collector: gathers one move per player, issues setup/manche commands to the
// game datapath and tracks the result until game over.
module move_collector #(
    parameter int TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SETUP_REQ,
    input  logic [3:0] SETUP_MANCHE,
    input  logic       P1_VALID,
    input  logic [1:0] P1_MOSSA,
    input  logic       P2_VALID,
    input  logic [1:0] P2_MOSSA,
    input  logic [1:0] MANCHE,
    input  logic [1:0] PARTITA,
    output logic       INIZIO_SETUP,
    output logic       INIZIO_CONTO,
    output logic [1:0] PRIMO,
    output logic [1:0] SECONDO,
    output logic       P1_ACK,
    output logic       P2_ACK,
    output logic [1:0] ULTIMA_MANCHE,
    output logic [1:0] ESITO,
    output logic       GAME_OVER,
    output logic       BUSY
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, SETUP, WAIT_MOVES, ISSUE, RESULT, OVER} state_t;

    state_t          state_q, state_d;
    logic            f1_q, f1_d, f2_q, f2_d;
    logic [1:0]      mv1_q, mv1_d, mv2_q, mv2_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            go, in_wait, tmo, cap1, cap2;
    logic            inizio_setup_d, inizio_conto_d, p1_ack_d, p2_ack_d, game_over_d, busy_d;
    logic [1:0]      primo_d, secondo_d, ultima_d, esito_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            f1_q          <= 1'b0;
            f2_q          <= 1'b0;
            mv1_q         <= 2'b00;
            mv2_q         <= 2'b00;
            cnt_q         <= '0;
            INIZIO_SETUP  <= 1'b0;
            INIZIO_CONTO  <= 1'b0;
            PRIMO         <= 2'b00;
            SECONDO       <= 2'b00;
            P1_ACK        <= 1'b0;
            P2_ACK        <= 1'b0;
            ULTIMA_MANCHE <= 2'b00;
            ESITO         <= 2'b00;
            GAME_OVER     <= 1'b0;
            BUSY          <= 1'b0;
        end else begin
            state_q       <= state_d;
            f1_q          <= f1_d;
            f2_q          <= f2_d;
            mv1_q         <= mv1_d;
            mv2_q         <= mv2_d;
            cnt_q         <= cnt_d;
            INIZIO_SETUP  <= inizio_setup_d;
            INIZIO_CONTO  <= inizio_conto_d;
            PRIMO         <= primo_d;
            SECONDO       <= secondo_d;
            P1_ACK        <= p1_ack_d;
            P2_ACK        <= p2_ack_d;
            ULTIMA_MANCHE <= ultima_d;
            ESITO         <= esito_d;
            GAME_OVER     <= game_over_d;
            BUSY          <= busy_d;
        end
    end

    // A timeout marks a missing player as captured with move 00, so the
    // "both flags set" rule alone decides when to issue the manche.
    always_comb begin
        go      = SETUP_REQ && state_q != SETUP;
        in_wait = state_q == WAIT_MOVES && !go;
        tmo     = in_wait && cnt_q == CW'(TIMEOUT - 1);
        cap1    = in_wait && P1_VALID && !f1_q;
        cap2    = in_wait && P2_VALID && !f2_q;
        f1_d    = (go || state_q == ISSUE) ? 1'b0 : f1_q || cap1 || tmo;
        f2_d    = (go || state_q == ISSUE) ? 1'b0 : f2_q || cap2 || tmo;
        mv1_d   = cap1 ? P1_MOSSA : (tmo && !f1_q) ? 2'b00 : mv1_q;
        mv2_d   = cap2 ? P2_MOSSA : (tmo && !f2_q) ? 2'b00 : mv2_q;
        cnt_d   = in_wait ? cnt_q + 1'b1 : '0;
        state_d = state_q;
        if (go)
            state_d = SETUP;
        else
            case (state_q)
                SETUP:      state_d = WAIT_MOVES;
                WAIT_MOVES: state_d = (f1_d && f2_d) ? ISSUE : WAIT_MOVES;
                ISSUE:      state_d = RESULT;
                RESULT:     state_d = (PARTITA != 2'b00) ? OVER : WAIT_MOVES;
                default:    state_d = state_q;
            endcase
    end

    always_comb begin
        inizio_setup_d = state_d == SETUP;
        inizio_conto_d = state_d == ISSUE;
        primo_d        = state_d == SETUP ? SETUP_MANCHE[1:0] : state_d == ISSUE ? mv1_d : 2'b00;
        secondo_d      = state_d == SETUP ? SETUP_MANCHE[3:2] : state_d == ISSUE ? mv2_d : 2'b00;
        p1_ack_d       = cap1;
        p2_ack_d       = cap2;
        ultima_d       = go ? 2'b00 : state_q == RESULT ? MANCHE : ULTIMA_MANCHE;
        esito_d        = go ? 2'b00 : (state_q == RESULT && PARTITA != 2'b00) ? PARTITA : ESITO;
        game_over_d    = state_d == OVER;
        busy_d         = state_d inside {SETUP, ISSUE, RESULT};
    end
endmodule

// File: tb/tb_move_collector.sv
// tb_move_collector: randomized manches checked against timing derived from the
// move collection rules (capture times, timeout, result handling).
module tb_move_collector;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       SETUP_REQ = 1'b0;
    logic [3:0] SETUP_MANCHE = 4'd0;
    logic       P1_VALID = 1'b0, P2_VALID = 1'b0;
    logic [1:0] P1_MOSSA = 2'd0, P2_MOSSA = 2'd0, MANCHE = 2'd0, PARTITA = 2'd0;
    logic       INIZIO_SETUP, INIZIO_CONTO, P1_ACK, P2_ACK, GAME_OVER, BUSY;
    logic [1:0] PRIMO, SECONDO, ULTIMA_MANCHE, ESITO;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [1:0] ult_m = 2'd0, esi_m = 2'd0;
    logic       over_m = 1'b0;

    always #5 clk = ~clk;

    move_collector #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .SETUP_REQ(SETUP_REQ), .SETUP_MANCHE(SETUP_MANCHE),
        .P1_VALID(P1_VALID), .P1_MOSSA(P1_MOSSA), .P2_VALID(P2_VALID), .P2_MOSSA(P2_MOSSA),
        .MANCHE(MANCHE), .PARTITA(PARTITA), .INIZIO_SETUP(INIZIO_SETUP),
        .INIZIO_CONTO(INIZIO_CONTO), .PRIMO(PRIMO), .SECONDO(SECONDO),
        .P1_ACK(P1_ACK), .P2_ACK(P2_ACK), .ULTIMA_MANCHE(ULTIMA_MANCHE),
        .ESITO(ESITO), .GAME_OVER(GAME_OVER), .BUSY(BUSY)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic junk;
        P1_VALID     = 1'($urandom);
        P2_VALID     = 1'($urandom);
        P1_MOSSA     = 2'($urandom);
        P2_MOSSA     = 2'($urandom);
        MANCHE       = 2'($urandom);
        PARTITA      = 2'($urandom);
        SETUP_MANCHE = 4'($urandom);
    endtask

    task automatic expect_out(input string tag, input logic a1, input logic a2, input logic is,
                              input logic ic, input logic [1:0] pr, input logic [1:0] se,
                              input logic bz);
        check({tag, ".p1_ack"}, P1_ACK, a1);
        check({tag, ".p2_ack"}, P2_ACK, a2);
        check({tag, ".inizio_setup"}, INIZIO_SETUP, is);
        check({tag, ".inizio_conto"}, INIZIO_CONTO, ic);
        check({tag, ".primo"}, PRIMO, pr);
        check({tag, ".secondo"}, SECONDO, se);
        check({tag, ".busy"}, BUSY, bz);
        check({tag, ".ultima"}, ULTIMA_MANCHE, ult_m);
        check({tag, ".esito"}, ESITO, esi_m);
        check({tag, ".game_over"}, GAME_OVER, over_m);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        SETUP_REQ = 1'($urandom);
        junk;
        repeat (n) step;
        ult_m = 2'd0; esi_m = 2'd0; over_m = 1'b0;
        expect_out("reset", 0, 0, 0, 0, 2'd0, 2'd0, 0);
        rst = 1'b0;
        SETUP_REQ = 1'b0;
        repeat (3) begin
            junk;
            step;
            expect_out("idle", 0, 0, 0, 0, 2'd0, 2'd0, 0);
        end
    endtask

    task automatic do_setup(input logic [3:0] sm);
        junk;
        SETUP_REQ = 1'b1;
        SETUP_MANCHE = sm;
        step;
        ult_m = 2'd0; esi_m = 2'd0; over_m = 1'b0;
        expect_out("setup", 0, 0, 1, 0, sm[1:0], sm[3:2], 1);
        SETUP_REQ = 1'b0;
        junk;
        step;
        expect_out("wait_entry", 0, 0, 0, 0, 2'd0, 2'd0, 0);
    endtask

    // mode 0: normal manche, 1: abort by SETUP_REQ while waiting, 2: rst in the ISSUE cycle.
    // need_setup reports that the block ended in OVER or IDLE.
    task automatic manche(input int mode, output logic need_setup);
        int t1, t2, e, ab;
        logic [1:0] m1, m2, mr, pt, ex1, ex2;
        t1 = $urandom_range(TO + 2, 0);
        t2 = ($urandom_range(3, 0) == 0) ? t1 : $urandom_range(TO + 2, 0);
        m1 = 2'($urandom);
        m2 = 2'($urandom);
        e  = (t1 < TO && t2 < TO) ? (t1 > t2 ? t1 : t2) : TO - 1;
        ex1 = t1 < TO ? m1 : 2'd0;
        ex2 = t2 < TO ? m2 : 2'd0;
        ab = mode == 1 ? $urandom_range(e, 0) : -1;
        need_setup = 1'b0;
        for (int i = 0; i <= e; i++) begin
            junk;
            SETUP_REQ = i == ab;
            P1_VALID = i == t1 || (i > t1 && 1'($urandom));
            P2_VALID = i == t2 || (i > t2 && 1'($urandom));
            if (i == t1) P1_MOSSA = m1;
            if (i == t2) P2_MOSSA = m2;
            if (i <= t1 && i != t1) P1_VALID = 1'b0;
            if (i <= t2 && i != t2) P2_VALID = 1'b0;
            if (i == ab) begin
                P1_VALID = 1'b1;
                P2_VALID = 1'b1;
                step;
                ult_m = 2'd0; esi_m = 2'd0; over_m = 1'b0;
                expect_out("abort", 0, 0, 1, 0, SETUP_MANCHE[1:0], SETUP_MANCHE[3:2], 1);
                SETUP_REQ = 1'b0;
                junk;
                step;
                expect_out("abort_wait", 0, 0, 0, 0, 2'd0, 2'd0, 0);
                return;
            end
            step;
            expect_out("wait", i == t1, i == t2, 0, i == e,
                       i == e ? ex1 : 2'd0, i == e ? ex2 : 2'd0, i == e);
        end
        SETUP_REQ = 1'b0;
        if (mode == 2) begin
            do_reset(1);
            need_setup = 1'b1;
            return;
        end
        junk;
        step;
        expect_out("result_entry", 0, 0, 0, 0, 2'd0, 2'd0, 1);
        junk;
        mr = 2'($urandom);
        pt = ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'd0;
        MANCHE = mr;
        PARTITA = pt;
        step;
        ult_m = mr;
        if (pt != 2'd0) begin
            esi_m = pt;
            over_m = 1'b1;
        end
        expect_out("result", 0, 0, 0, 0, 2'd0, 2'd0, 0);
        need_setup = pt != 2'd0;
        if (need_setup)
            repeat (4) begin
                junk;
                step;
                expect_out("over", 0, 0, 0, 0, 2'd0, 2'd0, 0);
            end
    endtask

    initial begin
        logic ns;
        int r;
        do_reset(2);
        do_setup(4'b0110);
        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(9, 0);
            manche(r == 0 ? 1 : r == 1 ? 2 : 0, ns);
            if (ns) do_setup(4'($urandom));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule

// File: doc/move_collector.md
# move_collector

Upstream input stage of the rock-paper-scissors game datapath. Collects one move per player from two independent, asynchronous-in-time strobe interfaces and sequences the datapath. It issues the one-cycle INIZIO_SETUP command with the configured manche count. It presents both moves together with a one-cycle INIZIO_CONTO, then reads back MANCHE/PARTITA to decide whether to collect the next manche or stop at game over. A per-manche timeout forces a missing move to 00 (invalid), so the game cannot stall.

## Interface
- TIMEOUT, 1000: cycles allowed in WAIT_MOVES before missing moves are forced to 00; legal range ≥ 2; counter width $clog2(TIMEOUT).

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- SETUP_REQ  in  1  start/restart a game; sampled every cycle
- SETUP_MANCHE  in  4  manche configuration, forwarded as {SECONDO,PRIMO} during setup
- P1_VALID  in  1  player 1 move strobe
- P1_MOSSA  in  2  player 1 move (01 sasso, 10 carta, 11 forbice, 00 invalid)
- P2_VALID  in  1  player 2 move strobe
- P2_MOSSA  in  2  player 2 move
- MANCHE  in  2  datapath manche result
- PARTITA  in  2  datapath game result; 00 = game still running
- INIZIO_SETUP  out  1  to datapath; high exactly one cycle per setup
- INIZIO_CONTO  out  1  to datapath; high exactly one cycle per manche
- PRIMO  out  2  to datapath; player 1 move, or SETUP_MANCHE[1:0] during setup
- SECONDO  out  2  to datapath; player 2 move, or SETUP_MANCHE[3:2] during setup
- P1_ACK  out  1  one-cycle pulse: player 1 move accepted
- P2_ACK  out  1  one-cycle pulse: player 2 move accepted
- ULTIMA_MANCHE  out  2  last MANCHE sampled
- ESITO  out  2  PARTITA latched at game over
- GAME_OVER  out  1  high in OVER
- BUSY  out  1  high in SETUP, ISSUE, RESULT

## Operation
- States: IDLE, SETUP, WAIT_MOVES, ISSUE, RESULT, OVER. All outputs registered.
- Reset behaviour:
  - rst has priority over everything. Reset state is IDLE.
  - All outputs, captured moves, capture flags and the timeout counter reset to 0.
  - rst mid-manche discards captured moves with no ACK.
- SETUP_REQ:
  - From any state except SETUP, SETUP_REQ=1 moves the block to SETUP.
  - This aborts any partial manche: capture flags are cleared and ESITO, ULTIMA_MANCHE and GAME_OVER are set to 0.
  - SETUP_REQ wins over simultaneous move strobes.
- IDLE: move strobes are ignored and no ACK is given.
- SETUP: INIZIO_SETUP=1, PRIMO=SETUP_MANCHE[1:0], SECONDO=SETUP_MANCHE[3:2]. Next state is WAIT_MOVES.
- WAIT_MOVES, capture rules:
  - On a Px_VALID while player x is not yet captured: store Px_MOSSA (00 included), set the flag and pulse Px_ACK.
  - Repeat strobes from an already captured player are ignored; the stored move is not overwritten and no ACK is given.
  - Both strobes in the same cycle: both are captured.
  - When both flags are set (including the capture cycle), the next state is ISSUE.
- WAIT_MOVES, timeout:
  - The counter is cleared on entry and increments each cycle.
  - At count TIMEOUT-1 with a flag still clear, the missing move(s) become 00 with no ACK, and the next state is ISSUE.
  - A strobe in the timeout cycle is captured normally and takes precedence over the forced 00.
- ISSUE: INIZIO_CONTO=1, PRIMO and SECONDO carry the captured moves, flags are cleared. Next state is RESULT.
- RESULT:
  - MANCHE → ULTIMA_MANCHE.
  - If PARTITA≠00: PARTITA → ESITO, next state OVER. Otherwise next state WAIT_MOVES.
- OVER: GAME_OVER=1 and moves are ignored. The block stays in OVER until SETUP_REQ.
- Outside SETUP and ISSUE, PRIMO and SECONDO are driven 00, and INIZIO_SETUP and INIZIO_CONTO are 0.

## Timing
- Setup: SETUP_REQ sampled at edge k → INIZIO_SETUP high during cycle k+1 → WAIT_MOVES from k+2.
- ACK: Px_VALID sampled at edge k → Px_ACK high during cycle k+1 only.
- Manche, normal completion:
  - Second move captured at edge k → INIZIO_CONTO high in cycle k+1.
  - RESULT is cycle k+2; MANCHE/PARTITA are sampled at the end of cycle k+2.
  - WAIT_MOVES or OVER from cycle k+3.
- Manche, timeout:
  - With no strobes, WAIT_MOVES lasts exactly TIMEOUT cycles, then ISSUE.
  - Total manche period is TIMEOUT+2 cycles.
- The datapath must present MANCHE/PARTITA one cycle after INIZIO_CONTO; the block does not wait longer.
- Back-to-back manches: minimum 3 cycles per manche when both strobes arrive in the first WAIT_MOVES cycle.

## Test plan
- Reset then setup: rst 2 cycles; SETUP_REQ with SETUP_MANCHE=4'b0110 → all outputs 0 after reset; one cycle of INIZIO_SETUP=1 with SECONDO=01, PRIMO=10; then WAIT_MOVES.
- Staggered moves: P1 10 at cycle 5, P2 11 at cycle 9, repeat P1 01 at cycle 7 → one ACK each; INIZIO_CONTO one cycle after the P2 capture with PRIMO=10, SECONDO=11; repeat strobe ignored.
- Simultaneous moves plus game end: both valid in the same cycle; model drives MANCHE=01, PARTITA=01 in RESULT → ULTIMA_MANCHE=01, ESITO=01, GAME_OVER=1; later strobes are not ACKed.
- Timeout with TIMEOUT=8: only P1 (01) strobes → INIZIO_CONTO 8 cycles after WAIT_MOVES entry with PRIMO=01, SECONDO=00; no P2_ACK.
- Abort: SETUP_REQ one cycle after a P1 capture → flags cleared, INIZIO_SETUP next cycle, no INIZIO_CONTO; a fresh manche then requires two new moves.
- rst asserted in the ISSUE cycle → next cycle IDLE, all outputs 0; strobes ignored until SETUP_REQ.
